// File: rtl/bram0_loader.sv
// Byte-stream packer feeding BRAM0: packs LANES stream elements per row, writes rows from
// address 0, then pulses start_run_o with the row count for the downstream accessor.
//
// state | meaning
// IDLE  | waiting for start_load_i, stream not accepted
// LOAD  | accepting bytes, writing one row per LANES bytes
// DONE  | one cycle; last row write strobe visible, launch pulse follows
module bram0_loader #(
  parameter int DWIDTH        = 32,
  parameter int IN_DATA_WIDTH = 8,
  parameter int AWIDTH        = 8,
  parameter int MEM_SIZE      = 256,
  parameter int CNT_BIT       = 31
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start_load_i,
  input  logic [CNT_BIT-1:0]       load_count_i,
  input  logic                     s_valid_i,
  input  logic [IN_DATA_WIDTH-1:0] s_data_i,
  output logic                     s_ready_o,
  output logic [AWIDTH-1:0]        addr_b0_o,
  output logic                     ce_b0_o,
  output logic                     we_b0_o,
  output logic [DWIDTH-1:0]        d_b0_o,
  output logic                     idle_o,
  output logic                     load_o,
  output logic                     done_o,
  output logic                     start_run_o,
  output logic [CNT_BIT-1:0]       run_count_o
);

  localparam int LANES = DWIDTH / IN_DATA_WIDTH;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PW    = DWIDTH - IN_DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [AWIDTH:0]     n_q;
  logic [AWIDTH:0]     row_cnt;
  logic [LW-1:0]       lane_cnt;
  logic [PW-1:0]       pack_q;
  logic [AWIDTH:0]     n_clamp;
  logic                hs;
  logic                last_lane;
  logic                last_row;

  // Clamping to MEM_SIZE guarantees row_cnt never needs to wrap the address.
  assign n_clamp   = (load_count_i > CNT_BIT'(MEM_SIZE)) ? (AWIDTH+1)'(MEM_SIZE)
                                                         : load_count_i[AWIDTH:0];
  assign hs        = s_valid_i & s_ready_o;
  assign last_lane = (lane_cnt == LW'(LANES - 1));
  assign last_row  = (row_cnt == (n_q - (AWIDTH+1)'(1)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_load_i) begin
          state_d = (n_clamp == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (hs && last_lane && last_row) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    s_ready_o = (state_q == S_LOAD);
    idle_o    = (state_q == S_IDLE);
    load_o    = (state_q == S_LOAD);
    done_o    = (state_q == S_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_q         <= '0;
      row_cnt     <= '0;
      lane_cnt    <= '0;
      pack_q      <= '0;
      addr_b0_o   <= '0;
      d_b0_o      <= '0;
      ce_b0_o     <= 1'b0;
      we_b0_o     <= 1'b0;
      start_run_o <= 1'b0;
      run_count_o <= '0;
    end else begin
      ce_b0_o     <= 1'b0;
      we_b0_o     <= 1'b0;
      start_run_o <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_load_i) begin
            n_q      <= n_clamp;
            row_cnt  <= '0;
            lane_cnt <= '0;
            pack_q   <= '0;
          end
        end
        S_LOAD: begin
          if (hs) begin
            lane_cnt <= lane_cnt + LW'(1);
            if (last_lane) begin
              // Top lane goes straight to the BRAM bus; it never needs to be held.
              ce_b0_o   <= 1'b1;
              we_b0_o   <= 1'b1;
              addr_b0_o <= row_cnt[AWIDTH-1:0];
              d_b0_o    <= {s_data_i, pack_q};
              row_cnt   <= row_cnt + (AWIDTH+1)'(1);
            end else begin
              pack_q[lane_cnt*IN_DATA_WIDTH +: IN_DATA_WIDTH] <= s_data_i;
            end
          end
        end
        S_DONE: begin
          start_run_o <= 1'b1;
          run_count_o <= CNT_BIT'(n_q);
        end
        default: ;
      endcase
    end
  end

endmodule
